// File: rtl/sequence_counter_pkg.sv
// sequence_counter_pkg: shared defaults, the fill/drain sequence table and index wrap helper.
package sequence_counter_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int SEQ_LEN_DEF = 8;
    localparam int TABLE_LEN = 8;
    localparam logic [3:0] SEQ_TABLE [0:TABLE_LEN-1] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

    // Out-of-range indices fall into the wrap branch, so they also recover to 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned len = SEQ_LEN_DEF);
        return (idx >= len - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/sequence_counter_rom.sv
// sequence_counter_rom: combinational SEQ_TABLE lookup; illegal indices read as 0.
module sequence_counter_rom
    import sequence_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int IW = $clog2(SEQ_LEN)
) (
    input  logic [IW-1:0]    idx_i,
    output logic [WIDTH-1:0] val_o
);
    always_comb begin
        val_o = (32'(idx_i) < SEQ_LEN) ? WIDTH'(SEQ_TABLE[idx_i]) : '0;
    end
endmodule

// File: rtl/sequence_counter.sv
// sequence_counter: free-running generator stepping count through SEQ_TABLE, one entry per clock.
module sequence_counter
    import sequence_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);
    localparam int IW = $clog2(SEQ_LEN);

    if (SEQ_LEN < 2 || SEQ_LEN > 16 || SEQ_LEN > TABLE_LEN) begin : g_len_chk
        $error("sequence_counter: SEQ_LEN %0d out of range", SEQ_LEN);
    end
    for (genvar i = 0; i < ((SEQ_LEN < TABLE_LEN) ? SEQ_LEN : TABLE_LEN); i++) begin : g_fit_chk
        if ((32'(SEQ_TABLE[i]) >> WIDTH) != 0) begin : g_err
            $error("sequence_counter: table entry %0d does not fit WIDTH", i);
        end
    end

    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        idx_d = IW'(next_idx(32'(idx_q), SEQ_LEN));
    end

    // Looking up the next index keeps count equal to SEQ_TABLE[idx] with no pipeline lag.
    sequence_counter_rom #(.WIDTH(WIDTH), .SEQ_LEN(SEQ_LEN), .IW(IW)) u_rom (
        .idx_i(idx_d),
        .val_o(count_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_sequence_counter.sv
// tb_sequence_counter: scoreboard bench; stimulus queues hand-computed values, a monitor checks each edge.
module tb_sequence_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count;
    logic [3:0] count6;

    logic [3:0] gold [0:7] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    logic [3:0] exp_q [$];
    logic [3:0] prev = 4'd0;
    int n_chk = 0;
    int n_fail = 0;
    int k = 0;

    sequence_counter dut (.clk(clk), .reset(reset), .count(count));
    sequence_counter #(.SEQ_LEN(6)) dut6 (.clk(clk), .reset(reset), .count(count6));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            k++;
            exp_q.push_back(gold[k % 8]);
        end
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: every edge taken out of reset must match the next queued value and flip one bit.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", 32'(count), 32'hFFFF_FFFF);
                end else begin
                    chk("sequence", 32'(count), 32'(exp_q.pop_front()));
                end
                chk("gray_step", $countones(count ^ prev), 1);
                prev = count;
            end
        end
    end

    always @(posedge reset) prev = 4'd0;

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("reset_t1", 32'(count), 0);
        @(posedge clk);
        #1;
        chk("reset_hold_edge", 32'(count), 0);
        chk("reset_hold_edge6", 32'(count6), 0);
        #3;
        reset = 1'b0;
        run_edges(6);
        chk("len6_wrap", 32'(count6), 0);
        run_edges(13);
        run_edges(1);
        chk("pre_reset_value", 32'(count), 15);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'(count), 0);
        k = 0;
        #3;
        reset = 1'b0;
        run_edges(2);
        k++;
        exp_q.push_back(gold[k % 8]);
        @(negedge clk);
        force dut6.idx_q = 3'd7;
        #1;
        chk("illegal_idx_next", 32'(dut6.idx_d), 0);
        @(posedge clk);
        #1;
        chk("illegal_recover", 32'(count6), 0);
        #1;
        release dut6.idx_q;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
